// File: rtl/snake_input_conditioner_pkg.sv
// Shared encodings for the snake game: headings, control states and turn codes.
// The game core imports this package as well.
package snake_pkg;

  localparam int unsigned BTN_W  = 3;
  localparam int unsigned DIR_W  = 2;
  localparam int unsigned QCNT_W = 2;

  typedef enum logic [DIR_W-1:0] {
    DIR_RIGHT = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } ctrl_state_t;

  localparam logic TURN_L = 1'b0;
  localparam logic TURN_R = 1'b1;

endpackage

// File: rtl/snake_input_conditioner_if.sv
// Button/control bundle between the board-side driver and the input conditioner.
interface snake_input_conditioner_if;
  import snake_pkg::*;

  logic [BTN_W-1:0]  btn;
  logic              step;
  logic              game_over;
  logic [DIR_W-1:0]  dir;
  logic              run;
  logic              start_pulse;
  logic [BTN_W-1:0]  btn_db;
  logic [QCNT_W-1:0] q_count;

  modport master (
    output btn, step, game_over,
    input  dir, run, start_pulse, btn_db, q_count
  );

  modport slave (
    input  btn, step, game_over,
    output dir, run, start_pulse, btn_db, q_count
  );
endinterface

// File: rtl/snake_input_conditioner_button_debouncer.sv
// One button: 2-flop synchronizer followed by a stability counter that
// only lets the debounced level follow after DEBOUNCE_CYCLES differing cycles.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db
);
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Counter only runs while the synchronized input disagrees with the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      btn_db <= 1'b0;
    end else if (sync2 == btn_db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_db <= sync2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snake_input_conditioner.sv
// Debounces {R,L,U}, runs the IDLE/RUN/PAUSE control FSM and buffers relative
// turns in a 2-deep FIFO that is drained one entry per game step.
module snake_input_conditioner
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                      CLK100MHZ,
  input  logic                      reset,
  snake_input_conditioner_if.slave  sic
);
  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);
  localparam logic [1:0] ST_PAUSE = 2'(PAUSE);

  logic [BTN_W-1:0]  db;
  logic [BTN_W-1:0]  db_d;
  logic [BTN_W-1:0]  press;

  logic [1:0]        state_q, state_n;
  logic [DIR_W-1:0]  dir_q, dir_n;
  logic [1:0]        q_q, q_n;
  logic [QCNT_W-1:0] cnt_q, cnt_n;
  logic              start_q, start_n;
  logic              run_q;
  logic              pop, push, new_turn;

  for (genvar i = 0; i < BTN_W; i++) begin : g_db
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (CLK100MHZ),
      .rst     (reset),
      .btn_raw (sic.btn[i]),
      .btn_db  (db[i])
    );
  end

  assign press = db & ~db_d;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_W'(DIR_RIGHT);
      q_q     <= '0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      run_q   <= 1'b0;
      db_d    <= '0;
    end else begin
      state_q <= state_n;
      dir_q   <= dir_n;
      q_q     <= q_n;
      cnt_q   <= cnt_n;
      start_q <= start_n;
      run_q   <= (state_n == ST_RUN);
      db_d    <= db;
    end
  end

  // q_n[0] is the FIFO head; a simultaneous L+R press cancels out.
  always_comb begin
    state_n  = state_q;
    dir_n    = dir_q;
    q_n      = q_q;
    cnt_n    = cnt_q;
    start_n  = 1'b0;
    pop      = 1'b0;
    push     = 1'b0;
    new_turn = press[2] ? TURN_R : TURN_L;
    case (state_q)
      ST_IDLE: begin
        if (press[0]) begin
          state_n = ST_RUN;
          start_n = 1'b1;
          dir_n   = DIR_W'(DIR_RIGHT);
          cnt_n   = '0;
        end
      end
      ST_RUN: begin
        if (sic.game_over) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          if (press[0]) state_n = ST_PAUSE;
          pop  = sic.step && (cnt_q != '0);
          push = press[1] ^ press[2];
          if (pop) dir_n = (q_q[0] == TURN_L) ? dir_q + DIR_W'(1) : dir_q - DIR_W'(1);
          case ({pop, push})
            2'b11: begin
              if (cnt_q == QCNT_W'(2)) begin
                q_n[0] = q_q[1];
                q_n[1] = new_turn;
              end else begin
                q_n[0] = new_turn;
              end
            end
            2'b10: begin
              q_n[0] = q_q[1];
              cnt_n  = cnt_q - QCNT_W'(1);
            end
            2'b01: begin
              if (cnt_q == QCNT_W'(0)) begin
                q_n[0] = new_turn;
                cnt_n  = QCNT_W'(1);
              end else if (cnt_q == QCNT_W'(1)) begin
                q_n[1] = new_turn;
                cnt_n  = QCNT_W'(2);
              end
            end
            default: ;
          endcase
        end
      end
      ST_PAUSE: begin
        if (press[0]) state_n = ST_RUN;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign sic.dir         = dir_q;
  assign sic.run         = run_q;
  assign sic.start_pulse = start_q;
  assign sic.btn_db      = db;
  assign sic.q_count     = cnt_q;

endmodule

// File: tb/tb_snake_input_conditioner.sv
// Bench for snake_input_conditioner: directed scenarios plus random button
// activity, compared cycle by cycle against a behavioural model.
module tb_snake_input_conditioner;
  import snake_pkg::*;

  localparam int unsigned DB = 4;

  logic CLK100MHZ = 1'b0;
  logic reset     = 1'b1;
  logic rst_v     = 1'b1;

  snake_input_conditioner_if sic ();

  snake_input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset),
    .sic       (sic)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  ctrl_state_t m_state;
  int          m_dir;
  bit          m_start;
  bit          mq[$];
  logic [2:0]  m_s1, m_s2, m_db, m_db_d;
  int          m_diff[3];

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = IDLE; m_dir = 0; m_start = 0; mq.delete();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_db_d = '0;
    foreach (m_diff[i]) m_diff[i] = 0;
  endtask

  // One clock edge of the reference, using the values present before the edge.
  task automatic model_clock(input logic [2:0] b, input logic st, input logic go);
    logic [2:0] pr;
    bit lr, popped, head;
    int n;
    pr = m_db & ~m_db_d;
    lr = pr[1] ^ pr[2];
    m_start = 0;
    popped = 0;
    n = mq.size();
    case (m_state)
      IDLE: if (pr[0]) begin
        m_state = RUN; m_start = 1; m_dir = 0; mq.delete();
      end
      RUN: begin
        if (go) begin
          m_state = IDLE; mq.delete();
        end else begin
          if (st && n > 0) begin
            head = mq.pop_front();
            popped = 1;
            m_dir = (head == TURN_L) ? (m_dir + 1) % 4 : (m_dir + 3) % 4;
          end
          if (lr && (n < 2 || popped)) mq.push_back(pr[2]);
          if (pr[0]) m_state = PAUSE;
        end
      end
      default: if (pr[0]) m_state = RUN;
    endcase
    m_db_d = m_db;
    // Level follows only after DB consecutive cycles of disagreement.
    for (int i = 0; i < 3; i++) begin
      if (m_s2[i] != m_db[i]) begin
        m_diff[i]++;
        if (m_diff[i] == DB) begin
          m_db[i] = m_s2[i];
          m_diff[i] = 0;
        end
      end else begin
        m_diff[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  task automatic compare_all();
    check_val("dir",         int'(sic.dir),         m_dir);
    check_val("run",         int'(sic.run),         int'(m_state == RUN));
    check_val("start_pulse", int'(sic.start_pulse), int'(m_start));
    check_val("btn_db",      int'(sic.btn_db),      int'(m_db));
    check_val("q_count",     int'(sic.q_count),     mq.size());
  endtask

  task automatic tick(input logic [2:0] b, input logic st, input logic go);
    @(negedge CLK100MHZ);
    sic.btn = b; sic.step = st; sic.game_over = go; reset = rst_v;
    @(posedge CLK100MHZ);
    if (rst_v) model_reset();
    else model_clock(b, st, go);
    #1 compare_all();
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(3'b000, 1'b0, 1'b0);
  endtask

  // Hold mask until debounced, then one more cycle (the press cycle) with st/go.
  task automatic press_btn(input logic [2:0] mask, input logic st, input logic go);
    int k;
    k = 0;
    while ((sic.btn_db & mask) != mask && k < 20) begin
      tick(mask, 1'b0, 1'b0);
      k++;
    end
    if ((sic.btn_db & mask) != mask) check_val("debounce_timeout", k, 6);
    tick(mask, st, go);
    idle_ticks(8);
  endtask

  initial begin
    int k;
    logic [2:0] m;
    int len;
    logic st, go;
    sic.btn = '0; sic.step = 1'b0; sic.game_over = 1'b0;
    model_reset();
    tick(3'b000, 1'b0, 1'b0);
    tick(3'b000, 1'b0, 1'b0);
    rst_v = 1'b0;
    tick(3'b000, 1'b0, 1'b0);
    check_val("reset_dir", int'(sic.dir), 0);
    check_val("reset_run", int'(sic.run), 0);
    check_val("reset_qcount", int'(sic.q_count), 0);

    // U held: btn_db[0] rises on the sixth edge after the raw change.
    k = 0;
    while (sic.btn_db[0] !== 1'b1 && k < 20) begin
      tick(3'b001, 1'b0, 1'b0);
      k++;
    end
    check_val("db_latency", k, 6);
    tick(3'b001, 1'b0, 1'b0);
    check_val("start_run", int'(sic.run), 1);
    check_val("start_pulse_hi", int'(sic.start_pulse), 1);
    tick(3'b001, 1'b0, 1'b0);
    check_val("start_pulse_lo", int'(sic.start_pulse), 0);
    idle_ticks(10);

    // Short L glitch is filtered.
    tick(3'b010, 1'b0, 1'b0);
    tick(3'b010, 1'b0, 1'b0);
    idle_ticks(8);
    check_val("glitch_q", int'(sic.q_count), 0);

    // L then R, three steps.
    press_btn(3'b010, 1'b0, 1'b0);
    press_btn(3'b100, 1'b0, 1'b0);
    check_val("lr_q", int'(sic.q_count), 2);
    tick(3'b000, 1'b1, 1'b0);
    check_val("step1_dir", int'(sic.dir), 1);
    tick(3'b000, 1'b1, 1'b0);
    check_val("step2_dir", int'(sic.dir), 0);
    tick(3'b000, 1'b1, 1'b0);
    check_val("step3_dir", int'(sic.dir), 0);
    check_val("step3_q", int'(sic.q_count), 0);

    // Saturation, then push coinciding with a pop on a full queue.
    press_btn(3'b010, 1'b0, 1'b0);
    press_btn(3'b010, 1'b0, 1'b0);
    press_btn(3'b010, 1'b0, 1'b0);
    check_val("sat_q", int'(sic.q_count), 2);
    press_btn(3'b010, 1'b1, 1'b0);
    check_val("pushpop_q", int'(sic.q_count), 2);
    check_val("pushpop_dir", int'(sic.dir), 1);

    // Pause: turns discarded, steps ignored, queue kept.
    press_btn(3'b001, 1'b0, 1'b0);
    check_val("pause_run", int'(sic.run), 0);
    press_btn(3'b100, 1'b0, 1'b0);
    tick(3'b000, 1'b1, 1'b0);
    check_val("pause_dir", int'(sic.dir), 1);
    press_btn(3'b001, 1'b0, 1'b0);
    check_val("resume_run", int'(sic.run), 1);
    check_val("resume_q", int'(sic.q_count), 2);

    // game_over beats U.
    press_btn(3'b001, 1'b0, 1'b1);
    check_val("go_run", int'(sic.run), 0);
    check_val("go_q", int'(sic.q_count), 0);

    // Back to RUN, turn away from 0, then async reset mid-debounce.
    press_btn(3'b001, 1'b0, 1'b0);
    press_btn(3'b010, 1'b1, 1'b0);
    press_btn(3'b010, 1'b0, 1'b0);
    tick(3'b000, 1'b1, 1'b0);
    check_val("pre_reset_dir", int'(sic.dir), 1);
    tick(3'b001, 1'b0, 1'b0);
    tick(3'b001, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check_val("async_dir", int'(sic.dir), 0);
    check_val("async_run", int'(sic.run), 0);
    check_val("async_db", int'(sic.btn_db), 0);
    check_val("async_q", int'(sic.q_count), 0);
    check_val("async_start", int'(sic.start_pulse), 0);
    rst_v = 1'b1;
    tick(3'b001, 1'b0, 1'b0);
    rst_v = 1'b0;
    for (int i = 0; i < 10; i++) tick(3'b001, 1'b0, 1'b0);
    check_val("held_thru_reset_run", int'(sic.run), 1);
    idle_ticks(8);

    // Random button activity, steps and game_over strobes.
    for (int s = 0; s < 400; s++) begin
      case ($urandom_range(0, 5))
        0: m = 3'b000;
        1: m = 3'b001;
        2: m = 3'b010;
        3: m = 3'b100;
        4: m = 3'b110;
        default: m = 3'($urandom_range(0, 7));
      endcase
      len = $urandom_range(1, 10);
      for (int c = 0; c < len; c++) begin
        st = ($urandom_range(0, 3) == 0);
        go = !st && ($urandom_range(0, 59) == 0);
        tick(m, st, go);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
